// File: rtl/axis_uart_streamer_pkg.sv
// Shared constants for the accelerometer UART streamer: ASCII glyphs, frame geometry,
// byte-transmitter state encoding and the nibble-to-hex helper.
package axis_uart_streamer_pkg;

  localparam logic [7:0] ASCII_X     = 8'h58;
  localparam logic [7:0] ASCII_Y     = 8'h59;
  localparam logic [7:0] ASCII_Z     = 8'h5A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int unsigned FRAME_LEN     = 22;
  localparam logic [4:0]  LAST_CHAR_IDX = 5'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Uppercase hex digit for a 4-bit value.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      hex_ascii = 8'h30 + {4'd0, n};
    end else begin
      hex_ascii = 8'h37 + {4'd0, n};
    end
  endfunction

endpackage

// File: rtl/axis_uart_streamer_uart_tx_byte.sv
// 8N1 byte transmitter. A start request during the last stop-bit cycle chains the
// next character straight into its start bit, so back-to-back bytes have no gap.
module uart_tx_byte
  import axis_uart_streamer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        baud_end;

  assign baud_end = (baud_q == BAUD_LAST);
  assign done     = (state_q == TX_STOP) && baud_end;
  assign tx       = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (start) begin
          state_d = TX_START;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      TX_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = TX_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          bit_d  = '0;
          if (start) begin
            state_d = TX_START;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: rtl/axis_uart_streamer.sv
// Snapshots one X/Y/Z accelerometer sample and streams it as "X:hhhh Y:hhhh Z:hhhh\r\n"
// over an 8N1 UART line, flagging samples that arrive while a frame is in flight.
module axis_uart_streamer
  import axis_uart_streamer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] x_data,
  input  logic [15:0] y_data,
  input  logic [15:0] z_data,
  output logic        tx_out,
  output logic        busy,
  output logic        sample_dropped
);

  logic [47:0] snap_q, snap_d;
  logic [4:0]  char_idx_q, char_idx_d;
  logic        launch_q, launch_d;
  logic        busy_q, busy_d;
  logic        dropped_q, dropped_d;

  logic        idle, accept, last_char;
  logic        tx_start, tx_done;
  logic [4:0]  char_sel;
  logic [7:0]  tx_char;
  logic [15:0] sx, sy, sz;

  assign sx = snap_q[47:32];
  assign sy = snap_q[31:16];
  assign sz = snap_q[15:0];

  // launch_q covers the one cycle between accept and the first start bit, so a
  // sample arriving then is treated as colliding with the frame.
  always_comb begin
    idle       = !busy_q && !launch_q;
    accept     = sample_valid && enable && idle;
    last_char  = (char_idx_q == LAST_CHAR_IDX);
    snap_d     = snap_q;
    char_idx_d = char_idx_q;
    launch_d   = accept;
    busy_d     = busy_q;
    dropped_d  = sample_valid && enable && !idle;
    if (accept) begin
      snap_d     = {x_data, y_data, z_data};
      char_idx_d = '0;
    end else if (tx_done && !last_char) begin
      char_idx_d = char_idx_q + 5'd1;
    end
    if (launch_q) begin
      busy_d = 1'b1;
    end else if (tx_done && last_char) begin
      busy_d = 1'b0;
    end
    tx_start = launch_q || (tx_done && !last_char);
    char_sel = launch_q ? char_idx_q : (char_idx_q + 5'd1);
  end

  always_comb begin
    tx_char = ASCII_SPACE;
    unique case (char_sel)
      5'd0:  tx_char = ASCII_X;
      5'd1:  tx_char = ASCII_COLON;
      5'd2:  tx_char = hex_ascii(sx[15:12]);
      5'd3:  tx_char = hex_ascii(sx[11:8]);
      5'd4:  tx_char = hex_ascii(sx[7:4]);
      5'd5:  tx_char = hex_ascii(sx[3:0]);
      5'd6:  tx_char = ASCII_SPACE;
      5'd7:  tx_char = ASCII_Y;
      5'd8:  tx_char = ASCII_COLON;
      5'd9:  tx_char = hex_ascii(sy[15:12]);
      5'd10: tx_char = hex_ascii(sy[11:8]);
      5'd11: tx_char = hex_ascii(sy[7:4]);
      5'd12: tx_char = hex_ascii(sy[3:0]);
      5'd13: tx_char = ASCII_SPACE;
      5'd14: tx_char = ASCII_Z;
      5'd15: tx_char = ASCII_COLON;
      5'd16: tx_char = hex_ascii(sz[15:12]);
      5'd17: tx_char = hex_ascii(sz[11:8]);
      5'd18: tx_char = hex_ascii(sz[7:4]);
      5'd19: tx_char = hex_ascii(sz[3:0]);
      5'd20: tx_char = ASCII_CR;
      5'd21: tx_char = ASCII_LF;
      default: tx_char = ASCII_SPACE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_idx_q <= '0;
      launch_q   <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      char_idx_q <= char_idx_d;
      launch_q   <= launch_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(tx_start),
    .data (tx_char),
    .tx   (tx_out),
    .done (tx_done)
  );

  assign busy           = busy_q;
  assign sample_dropped = dropped_q;

endmodule
